uart_rx_fifo: RTL and testbench

Receive-side byte buffer placed directly downstream of UART_Receiver. Captures each received byte and its parity/frame error flags on the receiver's single-cycle data_ready pulse. Presents them in order to the host/bus side over a valid/ready interface, first-word-fall-through. Reports fill level, a watermark interrupt and a sticky overrun flag when bytes are lost.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_fifo_mem.sv | 35 +++
 rtl/uart_rx_fifo.sv | 121 ++++++++++++
 tb/tb_uart_rx_fifo.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receive-entry payload and data width.
// Used by the receiver, the RX FIFO and the TX FIFO.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    // One received character plus its line-error flags.
    typedef struct packed {
        logic                   frame_err;
        logic                   parity_err;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

endpackage : uart_pkg

// File: rtl/uart_fifo_mem.sv
// uart_fifo_mem: DEPTH x rx_entry_t register array, one synchronous write
// port and one asynchronous read port. Storage is intentionally not reset.
//   clk   : clock
//   we    : write enable
//   waddr : write address
//   wdata : write payload
//   raddr : read address
//   rdata : read payload (combinational from raddr)
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = 16,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  rx_entry_t     wdata,
    input  logic [AW-1:0] raddr,
    output rx_entry_t     rdata
);

    rx_entry_t mem [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read port
    assign rdata = mem[raddr];

endmodule : uart_fifo_mem

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: first-word-fall-through receive buffer behind the UART
// receiver. Captures byte + error flags on the receiver's data_ready pulse,
// presents them over valid/ready, reports fill level, watermark and a sticky
// overrun flag.
//   clk, rst_n        : clock, async active-low reset
//   in_valid/in_*     : write strobe and received byte/flags
//   out_valid/ready   : head handshake; out_* head fields (zero when empty)
//   flush             : synchronous clear of contents
//   overrun_clr       : clears sticky overrun
//   count/full/empty  : fill status; level_irq = count >= THRESH
//   overrun           : sticky, a byte was dropped while full
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH  = 16,
    parameter  int unsigned THRESH = 8,
    localparam int unsigned CW     = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [UART_DATA_W-1:0] in_data,
    input  logic                   in_parity_err,
    input  logic                   in_frame_err,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [UART_DATA_W-1:0] out_data,
    output logic                   out_parity_err,
    output logic                   out_frame_err,
    input  logic                   flush,
    input  logic                   overrun_clr,
    output logic [CW-1:0]          count,
    output logic                   full,
    output logic                   empty,
    output logic                   level_irq,
    output logic                   overrun
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          overrun_q, overrun_d;

    logic          push_c;
    logic          pop_c;
    logic          drop_c;
    rx_entry_t     wr_entry;
    rx_entry_t     head_entry;

    // Status decoded from the count register only
    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign level_irq = (count_q >= CW'(THRESH));
    assign out_valid = ~empty;
    assign count     = count_q;
    assign overrun   = overrun_q;

    // Handshake qualification; a pop frees the slot a full-cycle push needs
    assign pop_c  = out_valid & out_ready & ~flush;
    assign push_c = in_valid & (~full | pop_c) & ~flush;
    assign drop_c = in_valid & full & ~pop_c & ~flush;

    assign wr_entry = '{frame_err: in_frame_err, parity_err: in_parity_err, data: in_data};

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_c),
        .waddr (wr_ptr_q),
        .wdata (wr_entry),
        .raddr (rd_ptr_q),
        .rdata (head_entry)
    );

    // Head fields gated so stale storage never leaks while empty
    assign out_data       = out_valid ? head_entry.data       : '0;
    assign out_parity_err = out_valid & head_entry.parity_err;
    assign out_frame_err  = out_valid & head_entry.frame_err;

    // Next-state for pointers, count and overrun
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_c) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push_c && !pop_c)      count_d = count_q + CW'(1);
            else if (pop_c && !push_c) count_d = count_q - CW'(1);
        end

        // A new drop wins over a coincident clear
        if (drop_c)           overrun_d = 1'b1;
        else if (overrun_clr) overrun_d = 1'b0;
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

endmodule : uart_rx_fifo

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model checked
// every cycle, plus directed literal expectations.
module tb_uart_rx_fifo;

    localparam int unsigned DEPTH  = 16;
    localparam int unsigned THRESH = 8;
    localparam int unsigned CW     = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_parity_err = 1'b0;
    logic          in_frame_err = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_data;
    logic          out_parity_err;
    logic          out_frame_err;
    logic          flush = 1'b0;
    logic          overrun_clr = 1'b0;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          level_irq;
    logic          overrun;

    int checks   = 0;
    int failures = 0;

    uart_rx_fifo #(.DEPTH(DEPTH), .THRESH(THRESH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_parity_err  (in_parity_err),
        .in_frame_err   (in_frame_err),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_parity_err (out_parity_err),
        .out_frame_err  (out_frame_err),
        .flush          (flush),
        .overrun_clr    (overrun_clr),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .level_irq      (level_irq),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ordered queue of {frame_err, parity_err, data}
    logic [9:0] m_q[$];
    bit         m_ovr;
    bit         m_full, m_pop, m_push, m_drop;
    logic [9:0] m_dummy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_ovr = 1'b0;
        end else begin
            m_full = (m_q.size() == DEPTH);
            m_pop  = (m_q.size() != 0) && out_ready && !flush;
            m_push = in_valid && (!m_full || m_pop) && !flush;
            m_drop = in_valid && m_full && !m_pop && !flush;
            if (flush) m_q.delete();
            if (m_pop) m_dummy = m_q.pop_front();
            if (m_push) m_q.push_back({in_frame_err, in_parity_err, in_data});
            if (m_drop) m_ovr = 1'b1;
            else if (overrun_clr) m_ovr = 1'b0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            logic [9:0] head;
            int         n;
            n    = m_q.size();
            head = (n != 0) ? m_q[0] : 10'h000;
            chk("m_count",     32'(count),          32'(n));
            chk("m_full",      32'(full),           32'(n == DEPTH));
            chk("m_empty",     32'(empty),          32'(n == 0));
            chk("m_out_valid", 32'(out_valid),      32'(n != 0));
            chk("m_level_irq", 32'(level_irq),      32'(n >= THRESH));
            chk("m_overrun",   32'(overrun),        32'(m_ovr));
            chk("m_out_data",  32'(out_data),       32'(head[7:0]));
            chk("m_out_perr",  32'(out_parity_err), 32'(head[8]));
            chk("m_out_ferr",  32'(out_frame_err),  32'(head[9]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic fe);
        in_valid      = 1'b1;
        in_data       = d;
        in_parity_err = pe;
        in_frame_err  = fe;
        tick();
        in_valid      = 1'b0;
        in_parity_err = 1'b0;
        in_frame_err  = 1'b0;
    endtask

    initial begin
        // Reset
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_empty",     32'(empty),     32'd1);
        chk("rst_full",      32'(full),      32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_overrun",   32'(overrun),   32'd0);
        chk("rst_level_irq", 32'(level_irq), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'h00);

        // Single byte, FWFT latency of one cycle
        push(8'hA5, 1'b0, 1'b0);
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data",  32'(out_data),  32'hA5);
        chk("single_count", 32'(count),     32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_empty", 32'(empty), 32'd1);

        // Fill to full, then drop one byte
        for (int i = 0; i < 16; i++) push(8'(i), 1'b0, 1'b0);
        chk("fill_full",    32'(full),    32'd1);
        chk("fill_count",   32'(count),   32'd16);
        chk("fill_overrun", 32'(overrun), 32'd0);
        push(8'hFF, 1'b0, 1'b0);
        chk("ovr_set",   32'(overrun),  32'd1);
        chk("ovr_count", 32'(count),    32'd16);
        chk("ovr_head",  32'(out_data), 32'h00);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("drain1_data", 32'(out_data), 32'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("drain1_empty",  32'(empty),   32'd1);
        chk("ovr_sticky",    32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        chk("ovr_cleared",   32'(overrun), 32'd0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i), 1'b0, 1'b0);
        out_ready = 1'b1;
        push(8'h55, 1'b0, 1'b0);
        out_ready = 1'b0;
        chk("pp_count",   32'(count),   32'd16);
        chk("pp_overrun", 32'(overrun), 32'd0);
        out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk("drain2_data", 32'(out_data), 32'(8'h20 + i));
            tick();
        end
        chk("drain2_last", 32'(out_data), 32'h55);
        tick();
        out_ready = 1'b0;
        chk("drain2_empty", 32'(empty), 32'd1);

        // Error flags and watermark crossing
        push(8'h3C, 1'b0, 1'b1);
        chk("flag_data", 32'(out_data),       32'h3C);
        chk("flag_ferr", 32'(out_frame_err),  32'd1);
        chk("flag_perr", 32'(out_parity_err), 32'd0);
        for (int i = 0; i < 6; i++) push(8'(8'h40 + i), 1'(i == 2), 1'b0);
        chk("wm_count7", 32'(count),     32'd7);
        chk("wm_low",    32'(level_irq), 32'd0);
        push(8'h4F, 1'b0, 1'b0);
        chk("wm_high",   32'(level_irq), 32'd1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("wm_fall",   32'(level_irq), 32'd0);
        chk("wm_next",   32'(out_data),  32'h40);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush1_count", 32'(count), 32'd0);

        // Flush coincident with push and pop
        for (int i = 0; i < 5; i++) push(8'(8'h60 + i), 1'b0, 1'b0);
        chk("pre_flush_count", 32'(count), 32'd5);
        flush     = 1'b1;
        out_ready = 1'b1;
        push(8'h99, 1'b0, 1'b0);
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("flush_count",   32'(count),   32'd0);
        chk("flush_empty",   32'(empty),   32'd1);
        chk("flush_overrun", 32'(overrun), 32'd0);

        // Asynchronous reset mid-burst
        for (int i = 0; i < 3; i++) push(8'(8'h70 + i), 1'b0, 1'b0);
        chk("refill_count", 32'(count), 32'd3);
        in_valid = 1'b1;
        in_data  = 8'h73;
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_empty", 32'(empty),     32'd1);
        chk("arst_count", 32'(count),     32'd0);
        chk("arst_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_empty", 32'(empty), 32'd1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx_fifo
